// File: rtl/alu_instr_encoder_pkg.sv
// alu_instr_encoder_pkg: ALU op codes, RV32I opcode/funct fields and the instruction packing helpers
package alu_instr_encoder_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // Codes above ALU_AND are unassigned and rejected by the encoder.
    function automatic logic op_defined(input logic [3:0] op);
        return op <= ALU_AND;
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    function automatic logic [2:0] f3_of(input logic [3:0] op);
        logic [2:0] f3;
        case (op)
            ALU_SLL:          f3 = F3_SLL;
            ALU_SLT:          f3 = F3_SLT;
            ALU_SLTU:         f3 = F3_SLTU;
            ALU_XOR:          f3 = F3_XOR;
            ALU_SRL, ALU_SRA: f3 = F3_SRL_SRA;
            ALU_OR:           f3 = F3_OR;
            ALU_AND:          f3 = F3_AND;
            default:          f3 = F3_ADD_SUB;
        endcase
        return f3;
    endfunction

    function automatic logic [6:0] f7_of(input logic [3:0] op);
        return ((op == ALU_SUB) || (op == ALU_SRA)) ? F7_ALT : F7_BASE;
    endfunction

    // Register form, shift-immediate form (shamt in imm[4:0]) or plain 12-bit immediate form.
    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic        imm_form,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = f3_of(op);
        f7 = f7_of(op);
        return !imm_form    ? {f7, rs2, rs1, f3, rd, OPC_OP} :
               is_shift(op) ? {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM} :
                              {imm, rs1, f3, rd, OPC_OP_IMM};
    endfunction

endpackage

// File: rtl/alu_instr_encoder_fifo.sv
// instr_fifo2: two-entry registered valid/ready FIFO; accepts a push on a full queue only alongside a pop
module instr_fifo2 #(
    parameter int             W       = 40,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    assign in_ready  = (cnt_q != 2'd2) || out_ready;
    assign out_valid = cnt_q != 2'd0;
    assign out_data  = mem_q[rd_ptr_q];

    // Pointer/count update; when full, the write slot equals the slot being popped this cycle.
    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        mem_d    = mem_q;
        if (push) mem_d[wr_ptr_q] = in_data;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + 2'(push) - 2'(pop);
    end

    // Storage and pointers; reset empties the queue and restores the idle output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: RST_VAL};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_instr_encoder.sv
// alu_instr_encoder: packs ALU requests into RV32I OP/OP-IMM words and streams them with word addresses
module alu_instr_encoder
    import alu_instr_encoder_pkg::*;
#(
    parameter int            AW        = 8,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_alu_op,
    input  logic          req_is_imm,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_rs1,
    input  logic [4:0]    req_rs2,
    input  logic [11:0]   req_imm,
    input  logic          addr_clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [AW-1:0] out_addr,
    output logic          err_pulse,
    output logic [7:0]    err_cnt
);

    logic [AW-1:0]    addr_q, addr_d;
    logic             err_pulse_q, err_pulse_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             legal, accept, enq_valid;
    logic [31:0]      instr;
    logic [31+AW:0]   fifo_out;

    // Legality, encoding and counters; illegal requests complete the handshake but never enqueue.
    always_comb begin
        accept      = req_valid && req_ready;
        legal       = op_defined(req_alu_op) && !(req_is_imm && (req_alu_op == ALU_SUB));
        enq_valid   = req_valid && legal;
        instr       = encode(req_alu_op, req_is_imm, req_rd, req_rs1, req_rs2, req_imm);
        addr_d      = addr_clr ? BASE_ADDR : (accept && legal) ? addr_q + AW'(1) : addr_q;
        err_pulse_d = accept && !legal;
        err_cnt_d   = err_cnt_q + 8'(err_pulse_d && (err_cnt_q != 8'hFF));
    end

    // Address counter and error reporting state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= BASE_ADDR;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            addr_q      <= addr_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    instr_fifo2 #(
        .W       (32 + AW),
        .RST_VAL ({32'd0, BASE_ADDR})
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (enq_valid),
        .in_ready  (req_ready),
        .in_data   ({instr, addr_q}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_out)
    );

    assign out_instr = fifo_out[31+AW:AW];
    assign out_addr  = fifo_out[AW-1:0];
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule
